// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine.
// Holds the ALU funct codes this block decodes plus a small decode helper.
package mul_div_unit_pkg;

  // ALU funct codes for the HI/LO producing instructions.
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic {
    OpMul,
    OpDiv
  } op_kind_e;

  function automatic logic is_mul_div(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] funct);
    return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-side bundle of the multiply/divide engine.
//   master: EX-stage pipeline (drives flush/en/funct/operands, sees stall/done/HI/LO)
//   slave : mul_div_unit
interface mul_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  flush;
  logic                  en;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  stall_request;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output flush, en, funct, operand_1, operand_2,
    input  stall_request, done, hi, lo
  );

  modport slave (
    input  flush, en, funct, operand_1, operand_2,
    output stall_request, done, hi, lo
  );
endinterface

// File: rtl/mul_div_sign_fix.sv
// Combinational conditional two's-complement negation of a double-width value.
//   value_i  : {hi half, lo half}
//   neg_hi_i : negate the hi half (or the whole value when joint_i is set)
//   neg_lo_i : negate the lo half (ignored when joint_i is set)
//   joint_i  : treat value_i as one 2*Width number (multiply product)
//   value_o  : corrected value
// Used both to take operand magnitudes on entry and to restore result signs on exit.
module mul_div_sign_fix #(
  parameter int unsigned Width = 32
) (
  input  logic [2*Width-1:0] value_i,
  input  logic               neg_hi_i,
  input  logic               neg_lo_i,
  input  logic               joint_i,
  output logic [2*Width-1:0] value_o
);

  logic [Width-1:0] hi_in, lo_in;

  assign hi_in = value_i[2*Width-1:Width];
  assign lo_in = value_i[Width-1:0];

  always_comb begin
    value_o = value_i;
    if (joint_i) begin
      if (neg_hi_i) value_o = -value_i;
    end else begin
      value_o[2*Width-1:Width] = neg_hi_i ? -hi_in : hi_in;
      value_o[Width-1:0]       = neg_lo_i ? -lo_in : lo_in;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative EX-stage multiply/divide engine (MULT/MULTU/DIV/DIVU), one bit per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mul_div_unit_if
//     flush/en/funct/operand_1/operand_2 in; stall_request/done/hi/lo out
// Latency: start cycle + DATA_WIDTH iterations with stall high, then a one-cycle DONE
// where done pulses and the freshly written HI/LO are visible.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  op_kind_e       op_kind_q, op_kind_d;
  logic           neg_quo_q, neg_quo_d;   // quotient / product sign
  logic           neg_rem_q, neg_rem_d;   // remainder follows the dividend
  logic           div_zero_q, div_zero_d;
  logic [W-1:0]   raw_a_q, raw_a_d;
  logic [W-1:0]   opnd_q, opnd_d;         // |operand_2|: multiplicand or divisor
  logic [2*W-1:0] acc_q, acc_d;           // mul: {partial, multiplier}; div: {rem, quo}
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  logic           start;
  logic           stall;
  logic           done;
  logic           op_signed;
  logic [2*W-1:0] abs_ops;

  assign op_signed = is_signed_op(bus.funct);
  // rst gates the start term so stall_request is low for the whole reset window.
  assign start = ~rst & bus.en & ~bus.flush & is_mul_div(bus.funct) & (state_q == StIdle);

  mul_div_sign_fix #(
    .Width (W)
  ) u_operand_fix (
    .value_i  ({bus.operand_1, bus.operand_2}),
    .neg_hi_i (op_signed & bus.operand_1[W-1]),
    .neg_lo_i (op_signed & bus.operand_2[W-1]),
    .joint_i  (1'b0),
    .value_o  (abs_ops)
  );

  // One iteration of either algorithm.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_shift;
  logic [W-1:0]   rem_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = rem_shift >= {1'b0, opnd_q};
    // Only used when div_ge, where the true difference fits in W bits.
    rem_diff  = rem_shift[W-1:0] - opnd_q;
    div_next  = {(div_ge ? rem_diff : rem_shift[W-1:0]), acc_q[W-2:0], div_ge};
    acc_next  = (op_kind_q == OpMul) ? mul_next : div_next;
  end

  logic [2*W-1:0] res_fixed;

  mul_div_sign_fix #(
    .Width (W)
  ) u_result_fix (
    .value_i  (acc_next),
    .neg_hi_i ((op_kind_q == OpMul) ? neg_quo_q : neg_rem_q),
    .neg_lo_i (neg_quo_q),
    .joint_i  (op_kind_q == OpMul),
    .value_o  (res_fixed)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_kind_d  = op_kind_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    raw_a_d    = raw_a_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stall      = 1'b0;
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          stall      = 1'b1;
          op_kind_d  = is_div_op(bus.funct) ? OpDiv : OpMul;
          neg_quo_d  = op_signed & (bus.operand_1[W-1] ^ bus.operand_2[W-1]);
          neg_rem_d  = op_signed & bus.operand_1[W-1];
          div_zero_d = (bus.operand_2 == '0);
          raw_a_d    = bus.operand_1;
          opnd_d     = abs_ops[W-1:0];
          acc_d      = {{W{1'b0}}, abs_ops[2*W-1:W]};
          cnt_d      = '0;
          state_d    = StCalc;
        end
      end
      StCalc: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            if ((op_kind_q == OpDiv) && div_zero_q) begin
              // Divide by zero: raw dividend in HI, all-ones quotient, no sign fix.
              hi_d = raw_a_q;
              lo_d = '1;
            end else begin
              {hi_d, lo_d} = res_fixed;
            end
          end
        end
      end
      StDone: begin
        done    = ~bus.flush;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_kind_q  <= OpMul;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      raw_a_q    <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_kind_q  <= op_kind_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      raw_a_q    <= raw_a_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.stall_request = stall;
  assign bus.done          = done;
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected HI/LO are queued when an op is issued
// and compared by a monitor when done pulses; timing is checked inside each test task.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  mul_div_unit_if #(.DATA_WIDTH(32)) bus ();

  mul_div_unit #(
    .DATA_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Result monitor: pops the scoreboard on every done pulse.
  always begin
    @(negedge clk);
    #2;
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done hi=%h lo=%h required=no result", bus.hi, bus.lo);
      end else begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (bus.hi !== mon_e.hi) $display("FAIL result_hi got=%h required=%h", bus.hi, mon_e.hi);
        else n_pass++;
        n_checks++;
        if (bus.lo !== mon_e.lo) $display("FAIL result_lo got=%h required=%h", bus.lo, mon_e.lo);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint sa, sb, q, rm;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f)
      FUNCT_MULTU: begin p = {32'b0, a} * {32'b0, b}; r = p; end
      FUNCT_MULT:  begin q = sa * sb; r = q; end
      FUNCT_DIVU: begin
        if (b == 0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else begin r.hi = a % b; r.lo = a / b; end
      end
      default: begin
        if (b == 0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; rm = sa % sb; r.hi = rm[31:0]; r.lo = q[31:0]; end
      end
    endcase
    return r;
  endfunction

  // Called at a negedge; holds the op in EX until done, returns at the negedge after done.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, output int stall_cnt, output int done_cyc);
    sb_q.push_back(e);
    bus.en = 1'b1;
    bus.funct = f;
    bus.operand_1 = a;
    bus.operand_2 = b;
    stall_cnt = 0;
    done_cyc  = -1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.stall_request === 1'b1) stall_cnt++;
      if (bus.done === 1'b1) done_cyc = c;
      @(negedge clk);
      if (done_cyc >= 0) break;
    end
    bus.en = 1'b0;
    if (done_cyc < 0) begin
      n_checks++;
      $display("FAIL op_timeout funct=%h got=no done required=done within 60 cycles", f);
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.flush = 1'b0; bus.funct = 6'h00;
    bus.operand_1 = '0; bus.operand_2 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got=%h required=0", bus.hi); else n_pass++;
    n_checks++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got=%h required=0", bus.lo); else n_pass++;
    n_checks++; if (bus.stall_request !== 1'b0) $display("FAIL reset_stall got=%b required=0", bus.stall_request); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b required=0", bus.done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic check_timing(input string name, input int stall_cnt, input int done_cyc);
    n_checks++;
    if (stall_cnt !== 33) $display("FAIL %s_stall_cycles got=%0d required=33", name, stall_cnt);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 33) $display("FAIL %s_done_cycle got=%0d required=33", name, done_cyc);
    else n_pass++;
  endtask

  task automatic test_multu_max();
    int s, d;
    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001}, s, d);
    check_timing("multu_max", s, d);
  endtask

  task automatic test_signed();
    int s, d;
    run_op(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, '{32'hFFFF_FFFF, 32'hFFFF_FFEB}, s, d);
    check_timing("mult_neg", s, d);
    run_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD}, s, d);
    check_timing("div_neg", s, d);
  endtask

  task automatic test_div_corner();
    int s, d;
    run_op(FUNCT_DIVU, 32'd100, 32'd0, '{32'h0000_0064, 32'hFFFF_FFFF}, s, d);
    check_timing("divu_zero", s, d);
    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0, 32'h8000_0000}, s, d);
    run_op(FUNCT_DIV, 32'hFFFF_FFFB, 32'd0, '{32'hFFFF_FFFB, 32'hFFFF_FFFF}, s, d);
    check_timing("div_zero_signed", s, d);
  endtask

  task automatic test_back_to_back();
    int s, d;
    run_op(FUNCT_DIVU, 32'd10, 32'd3, '{32'd1, 32'd3}, s, d);
    check_timing("b2b_first", s, d);
    // Second op enters EX in the cycle right after DONE.
    run_op(FUNCT_MULTU, 32'd6, 32'd7, '{32'd0, 32'd42}, s, d);
    check_timing("b2b_second", s, d);
  endtask

  task automatic test_random();
    logic [5:0]  fl[4];
    logic [5:0]  f;
    logic [31:0] a, b;
    int s, d;
    fl[0] = FUNCT_MULT; fl[1] = FUNCT_MULTU; fl[2] = FUNCT_DIV; fl[3] = FUNCT_DIVU;
    for (int i = 0; i < 8; i++) begin
      f = fl[i % 4];
      a = $urandom;
      b = (i >= 4) ? $urandom_range(1, 1000) : $urandom;
      if ($urandom_range(0, 1) == 1) b = -b;
      run_op(f, a, b, model(f, a, b), s, d);
      n_checks++;
      if (s !== 33) $display("FAIL random_stall_cycles got=%0d required=33", s);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    int s, d, late_stall, done_cnt;
    logic stall_c10;
    run_op(FUNCT_DIVU, 32'h0000_0451, 32'h0000_0020, '{32'h11, 32'h22}, s, d);
    bus.en = 1'b1; bus.funct = FUNCT_DIVU; bus.operand_1 = 32'd50; bus.operand_2 = 32'd5;
    late_stall = 0; done_cnt = 0; stall_c10 = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c == 10) bus.flush = 1'b1;
      if (c == 11) begin bus.flush = 1'b0; bus.en = 1'b0; end
      #1;
      if (c == 10) stall_c10 = bus.stall_request;
      if (c >= 11 && bus.stall_request === 1'b1) late_stall++;
      if (bus.done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_checks++; if (stall_c10 !== 1'b1) $display("FAIL flush_stall_c10 got=%b required=1", stall_c10); else n_pass++;
    n_checks++; if (late_stall !== 0) $display("FAIL flush_late_stall got=%0d required=0", late_stall); else n_pass++;
    n_checks++; if (done_cnt !== 0) $display("FAIL flush_done got=%0d required=0", done_cnt); else n_pass++;
    n_checks++; if (bus.hi !== 32'h11) $display("FAIL flush_hi got=%h required=11", bus.hi); else n_pass++;
    n_checks++; if (bus.lo !== 32'h22) $display("FAIL flush_lo got=%h required=22", bus.lo); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s, d;
    bus.en = 1'b1; bus.funct = FUNCT_MULTU;
    bus.operand_1 = 32'h0000_1234; bus.operand_2 = 32'h0000_5678;
    repeat (6) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.hi !== 32'h0) $display("FAIL midrst_hi got=%h required=0", bus.hi); else n_pass++;
    n_checks++; if (bus.lo !== 32'h0) $display("FAIL midrst_lo got=%h required=0", bus.lo); else n_pass++;
    n_checks++; if (bus.stall_request !== 1'b0) $display("FAIL midrst_stall got=%b required=0", bus.stall_request); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done got=%b required=0", bus.done); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    run_op(FUNCT_MULTU, 32'd2, 32'd3, '{32'd0, 32'd6}, s, d);
    check_timing("after_rst", s, d);
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_corner();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain got=%0d pending required=0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
